hazard_control_unit: RTL

//  Counterpart to the EX-stage forwarding logic: detects hazards forwarding cannot resolve.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/load_use_detect.sv | 22 ++
 rtl/hazard_control_unit.sv | 105 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller:
// FSM states, register-zero constant and control bundles.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic ifIdFlush;
    logic idExWrite;
    logic idExBubble;
    logic exMemBubble;
    logic mduBusy;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{
    pcWrite: 1'b1, ifIdWrite: 1'b1, ifIdFlush: 1'b0,
    idExWrite: 1'b1, idExBubble: 1'b0,
    exMemBubble: 1'b0, mduBusy: 1'b0
  };

  localparam ctrl_t CTRL_RESET = '{
    pcWrite: 1'b0, ifIdWrite: 1'b0, ifIdFlush: 1'b1,
    idExWrite: 1'b0, idExBubble: 1'b1,
    exMemBubble: 1'b1, mduBusy: 1'b0
  };

  localparam ctrl_t CTRL_MDU = '{
    pcWrite: 1'b0, ifIdWrite: 1'b0, ifIdFlush: 1'b0,
    idExWrite: 1'b0, idExBubble: 1'b0,
    exMemBubble: 1'b1, mduBusy: 1'b1
  };

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: a load in EX whose destination
// is read by the instruction in ID, excluding $0.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       memRead,
  input  logic [4:0] exRt,
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       usesRt,
  output logic       hazard
);

  logic rsMatch;
  logic rtMatch;

  assign rsMatch = (exRt == idRs);
  assign rtMatch = usesRt && (exRt == idRt);
  assign hazard  = memRead && (exRt != REG_ZERO)
                && (rsMatch || rtMatch);

endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for load-use, taken branch
// and multi-cycle MDU operations.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 4,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_EX_MemRead,
  input  logic [4:0]        ID_EX_RegisterRt,
  input  logic [4:0]        IF_ID_RegisterRs,
  input  logic [4:0]        IF_ID_RegisterRt,
  input  logic              IF_ID_UsesRt,
  input  logic              EX_BranchTaken,
  input  logic              EX_MduStart,
  output logic              PCWrite,
  output logic              IF_ID_Write,
  output logic              IF_ID_Flush,
  output logic              ID_EX_Write,
  output logic              ID_EX_Bubble,
  output logic              EX_MEM_Bubble,
  output logic              mdu_busy,
  output logic [PERF_W-1:0] StallCycles
);

  state_t            state;
  state_t            nextState;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  nextCnt;
  logic              luHazard;
  ctrl_t             ctrl;

  load_use_detect u_luDetect (
    .memRead (ID_EX_MemRead),
    .exRt    (ID_EX_RegisterRt),
    .idRs    (IF_ID_RegisterRs),
    .idRt    (IF_ID_RegisterRt),
    .usesRt  (IF_ID_UsesRt),
    .hazard  (luHazard)
  );

  always_comb begin
    ctrl      = CTRL_DEFAULT;
    nextState = state;
    nextCnt   = cnt;
    if (!rst_n) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state)
        RUN: begin
          if (EX_BranchTaken) begin
            ctrl.ifIdFlush  = 1'b1;
            ctrl.idExBubble = 1'b1;
          end else if (EX_MduStart) begin
            ctrl      = CTRL_MDU;
            nextState = MDU_WAIT;
            nextCnt   = CNT_W'(MDU_LATENCY - 1);
          end else if (luHazard) begin
            ctrl.pcWrite    = 1'b0;
            ctrl.ifIdWrite  = 1'b0;
            ctrl.idExBubble = 1'b1;
          end
        end
        // EX is frozen: hazard inputs are stale
        MDU_WAIT: begin
          ctrl    = CTRL_MDU;
          nextCnt = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) nextState = RUN;
        end
        default: nextState = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      StallCycles <= '0;
    end else if (!ctrl.pcWrite
                 && (StallCycles != {PERF_W{1'b1}})) begin
      StallCycles <= StallCycles + PERF_W'(1);
    end
  end

  assign PCWrite       = ctrl.pcWrite;
  assign IF_ID_Write   = ctrl.ifIdWrite;
  assign IF_ID_Flush   = ctrl.ifIdFlush;
  assign ID_EX_Write   = ctrl.idExWrite;
  assign ID_EX_Bubble  = ctrl.idExBubble;
  assign EX_MEM_Bubble = ctrl.exMemBubble;
  assign mdu_busy      = ctrl.mduBusy;

endmodule
